// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC for the audio PWM clock domain.
// Duty values arrive through a valid/ready port into per-channel shadow
// registers. They are copied to the active registers only at period
// boundaries, or on any cycle while the block is idle, so no output ever
// sees a partial period. The counter is either an edge-aligned sawtooth or a
// center-aligned triangle.
// Optional build macro PWM_DITHER_EN: duty words carry FRAC_BITS fractional
// bits. A per-channel accumulator stretches some periods by one count so the
// long-term average includes the fraction.
module pwm_dac_multi #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 10,
  parameter int CENTER_ALIGNED = 0,
  parameter int FRAC_BITS      = 2,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
`ifdef PWM_DITHER_EN
  localparam int DW            = WIDTH + FRAC_BITS
`else
  localparam int DW            = WIDTH
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic [CW-1:0]       duty_chan,
  input  logic [DW-1:0]       duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);
  localparam logic [CW:0]      CH_LIMIT = (CW + 1)'(CHANNELS);

  logic [WIDTH-1:0]    cnt_r;
  logic [WIDTH-1:0]    cnt_nxt_s;
  logic                dir_r;      // 0 = counting up, 1 = counting down
  logic                dir_nxt_s;
  logic                boundary_s;
  logic                xfer_s;
  logic                chan_ok_s;
  logic                accept_s;
  logic [DW-1:0]       shadow_r [CHANNELS];
  logic [DW-1:0]       active_r [CHANNELS];
  logic [CHANNELS-1:0] pending_r;
  logic [WIDTH-1:0]    duty_s [CHANNELS];
  logic [CHANNELS-1:0] pwm_nxt_s;

  // A boundary is the cnt==0 cycle of a running counter; while idle, every
  // cycle is a transfer point so that pending values land quickly.
  assign boundary_s = enable && (cnt_r == ZERO);
  assign xfer_s     = boundary_s || !enable;
  assign chan_ok_s  = ({1'b0, duty_chan} < CH_LIMIT);
  assign accept_s   = duty_valid && duty_ready;

  // Ready reflects the addressed channel; out-of-range channels always
  // accept, and the data is discarded.
  always_comb begin
    duty_ready = 1'b1;
    if (chan_ok_s) begin
      duty_ready = ~pending_r[duty_chan];
    end else begin
      duty_ready = 1'b1;
    end
  end

  // Next counter value: sawtooth 0..MAX, or triangle that turns at MAX and 1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    if (!enable) begin
      cnt_nxt_s = ZERO;
      dir_nxt_s = 1'b0;
    end else if (CENTER_ALIGNED == 0) begin
      cnt_nxt_s = cnt_r + ONE;
      dir_nxt_s = 1'b0;
    end else if (!dir_r) begin
      if (cnt_r == MAX) begin
        cnt_nxt_s = MAX - ONE;
        dir_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + ONE;
        dir_nxt_s = 1'b0;
      end
    end else begin
      cnt_nxt_s = cnt_r - ONE;
      if (cnt_r == ONE) begin
        dir_nxt_s = 1'b0;
      end else begin
        dir_nxt_s = 1'b1;
      end
    end
  end

`ifdef PWM_DITHER_EN
  logic [WIDTH-1:0]     cur_r     [CHANNELS];
  logic [FRAC_BITS-1:0] acc_r     [CHANNELS];
  logic [FRAC_BITS-1:0] acc_nxt_s [CHANNELS];
  logic [FRAC_BITS:0]   acc_sum_s [CHANNELS];

  // Period duty: on a transfer the new integer part applies at once with a
  // cleared accumulator; on other boundaries the fraction accumulates and a
  // carry stretches this period by one count, saturating at MAX.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_sum_s[i] = {1'b0, acc_r[i]} + {1'b0, active_r[i][FRAC_BITS-1:0]};
      acc_nxt_s[i] = acc_r[i];
      duty_s[i]    = cur_r[i];
      if (xfer_s && pending_r[i]) begin
        duty_s[i]    = shadow_r[i][DW-1:FRAC_BITS];
        acc_nxt_s[i] = {FRAC_BITS{1'b0}};
      end else if (boundary_s) begin
        acc_nxt_s[i] = acc_sum_s[i][FRAC_BITS-1:0];
        if (acc_sum_s[i][FRAC_BITS] && (active_r[i][DW-1:FRAC_BITS] != MAX)) begin
          duty_s[i] = active_r[i][DW-1:FRAC_BITS] + ONE;
        end else begin
          duty_s[i] = active_r[i][DW-1:FRAC_BITS];
        end
      end else begin
        duty_s[i]    = cur_r[i];
        acc_nxt_s[i] = acc_r[i];
      end
    end
  end

  // Hold the duty chosen for the current period and the dither accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cur_r[i] <= ZERO;
        acc_r[i] <= {FRAC_BITS{1'b0}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cur_r[i] <= duty_s[i];
        acc_r[i] <= acc_nxt_s[i];
      end
    end
  end
`else
  // Effective duty: a value transferring this cycle already governs the
  // compare, so the first period with a new duty is complete.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_s[i] = active_r[i][WIDTH-1:0];
      if (xfer_s && pending_r[i]) begin
        duty_s[i] = shadow_r[i][WIDTH-1:0];
      end else begin
        duty_s[i] = active_r[i][WIDTH-1:0];
      end
    end
  end
`endif

  // Compare stage; MAX is forced high so that full scale is a true 100%.
  always_comb begin
    pwm_nxt_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable) begin
        pwm_nxt_s[i] = 1'b0;
      end else if (duty_s[i] == MAX) begin
        pwm_nxt_s[i] = 1'b1;
      end else begin
        pwm_nxt_s[i] = (cnt_r < duty_s[i]);
      end
    end
  end

  // Counter, direction and registered period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= ZERO;
      dir_r        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      dir_r        <= dir_nxt_s;
      period_start <= boundary_s;
    end
  end

  // Shadow capture on accept, shadow-to-active transfer, and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {CHANNELS{1'b0}};
      pwm_out   <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= {DW{1'b0}};
        active_r[i] <= {DW{1'b0}};
      end
    end else begin
      pwm_out <= pwm_nxt_s;
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept_s && chan_ok_s && (duty_chan == CW'(i))) begin
          shadow_r[i]  <= duty_data;
          pending_r[i] <= 1'b1;
        end else if (xfer_s && pending_r[i]) begin
          active_r[i]  <= shadow_r[i];
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed testbench for pwm_dac_multi: an edge-aligned 3-channel instance
// and a center-aligned 2-channel instance, both with WIDTH=4 (MAX=15).
// Output windows are sampled on the falling edge; each window starts in the
// period_start cycle, so bit k of a mask is the compare result for count k.
module tb_pwm_dac_multi;

  localparam int W = 4;
`ifdef PWM_DITHER_EN
  localparam int DW = W + 2;
`else
  localparam int DW = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, valid;
  logic [1:0]    chan;
  logic [DW-1:0] data;
  logic [2:0]    pwm;
  logic          ps, ready;
  logic          c_en, c_valid;
  logic [0:0]    c_chan;
  logic [DW-1:0] c_data;
  logic [1:0]    c_pwm;
  logic          c_ps, c_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  pwm_dac_multi #(.CHANNELS(3), .WIDTH(W), .CENTER_ALIGNED(0), .FRAC_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .duty_valid(valid), .duty_ready(ready),
    .duty_chan(chan), .duty_data(data), .pwm_out(pwm), .period_start(ps)
  );

  pwm_dac_multi #(.CHANNELS(2), .WIDTH(W), .CENTER_ALIGNED(1), .FRAC_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(c_en), .duty_valid(c_valid), .duty_ready(c_ready),
    .duty_chan(c_chan), .duty_data(c_data), .pwm_out(c_pwm), .period_start(c_ps)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int v);
`ifdef PWM_DITHER_EN
    mk = DW'(v << 2);
`else
    mk = DW'(v);
`endif
  endfunction

  task automatic wait_ps(input bit ctr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((ctr ? c_ps : ps) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("period_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic settle();
    wait_ps(1'b0);
    wait_ps(1'b0);
  endtask

  task automatic measure(input bit ctr, input int n, output logic [31:0] m0,
                         output logic [31:0] m1, output logic [31:0] m2, output int pc);
    m0 = 32'd0; m1 = 32'd0; m2 = 32'd0; pc = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (ctr) begin
        m0[k] = c_pwm[0]; m1[k] = c_pwm[1]; pc += int'(c_ps);
      end else begin
        m0[k] = pwm[0]; m1[k] = pwm[1]; m2[k] = pwm[2]; pc += int'(ps);
      end
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [DW-1:0] d, output int w);
    chan = ch; data = d; valid = 1'b1;
    #1;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("write_accept_bound", 32'(w < 100), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  logic [31:0] m0, m1, m2;
  int pc, w, s0, s1, spc;

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus and checks.
  initial begin
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; chan = 2'd0; data = '0;
    c_en = 1'b0; c_valid = 1'b0; c_chan = 1'b0; c_data = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ps", 32'(ps), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_c_pwm", 32'(c_pwm), 32'd0);
    rst_n = 1'b1; en = 1'b1;

    // ch0 duty 4: high for counts 0..3 of each 16-cycle period.
    @(negedge clk);
    wr(2'd0, mk(4), w);
    settle();
    measure(1'b0, 16, m0, m1, m2, pc);
    check("edge_d4_mask", m0, 32'h0000_000F);
    check("edge_ps_per_period", 32'(pc), 32'd1);

    // ch1 6 then 9 in one period; the second write stalls, ch0 does not.
    wait_ps(1'b0);
    wr(2'd1, mk(6), w);
    @(negedge clk);
    chan = 2'd1; data = mk(9); valid = 1'b1;
    #1 check("ch1_second_write_stalls", 32'(ready), 32'd0);
    chan = 2'd0; data = mk(4);
    #1 check("ch0_not_stalled", 32'(ready), 32'd1);
    @(posedge clk);
    #1 chan = 2'd1; data = mk(9);
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ch1_stall_bound", 32'(w < 100), 32'd1);
    check("ch1_release_at_boundary", 32'(ps), 32'd1);
    fork
      begin
        @(posedge clk);
        #1 valid = 1'b0;
      end
    join_none
    measure(1'b0, 16, m0, m1, m2, pc);
    check("ch1_first_period_6", m1, 32'h0000_003F);
    check("ch0_during_ch1_6", m0, 32'h0000_000F);
    @(negedge clk);
    measure(1'b0, 16, m0, m1, m2, pc);
    check("ch1_second_period_9", m1, 32'h0000_01FF);
    check("ch1_period_ps", 32'(pc), 32'd1);

    // Extremes: 0 is constant low, MAX is constant high over 3 periods.
    @(negedge clk);
    wr(2'd0, mk(0), w);
    wr(2'd1, mk(15), w);
    settle();
    s0 = 0; s1 = 0; spc = 0;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) @(negedge clk);
      measure(1'b0, 16, m0, m1, m2, pc);
      s0 += $countones(m0); s1 += $countones(m1); spc += pc;
    end
    check("duty0_high_cycles", 32'(s0), 32'd0);
    check("dutymax_high_cycles", 32'(s1), 32'd48);
    check("extremes_ps_count", 32'(spc), 32'd3);

    // Out-of-range channel: accepted at once, no output changes anywhere.
    chan = 2'd3; data = mk(5);
    #1 check("oob_ready", 32'(ready), 32'd1);
    wr(2'd3, mk(5), w);
    check("oob_no_wait", 32'(w), 32'd0);
    settle();
    measure(1'b0, 16, m0, m1, m2, pc);
    check("oob_ch0", m0, 32'h0000_0000);
    check("oob_ch1", m1, 32'h0000_FFFF);
    check("oob_ch2", m2, 32'h0000_0000);

    // Reset mid-period with a pending write: everything clears, nothing applies.
    wr(2'd0, mk(7), w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; chan = 2'd0;
    #1;
    check("midrst_pwm", 32'(pwm), 32'd0);
    check("midrst_ps", 32'(ps), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    measure(1'b0, 16, m0, m1, m2, pc);
    check("after_rst_ch0", m0, 32'h0000_0000);
    check("after_rst_ch1", m1, 32'h0000_0000);

    // Idle: writes still land; enable rise starts a fresh period.
    en = 1'b0;
    wr(2'd0, mk(8), w);
    repeat (3) @(negedge clk);
    check("idle_pwm", 32'(pwm), 32'd0);
    check("idle_ps", 32'(ps), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("enable_rise_ps", 32'(ps), 32'd1);
    measure(1'b0, 16, m0, m1, m2, pc);
    check("idle_write_applied", m0, 32'h0000_00FF);

    // Enable falling mid-period drops outputs; re-enable restarts at count 0.
    @(negedge clk);
    @(negedge clk);
    check("pre_disable_high", 32'(pwm[0]), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("disable_pwm_low", 32'(pwm[0]), 32'd0);
    check("disable_ps_low", 32'(ps), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("reenable_ps", 32'(ps), 32'd1);
    measure(1'b0, 16, m0, m1, m2, pc);
    check("reenable_full_period", m0, 32'h0000_00FF);

`ifdef PWM_DITHER_EN
    // Dither: int 4 frac 1/4 gives 4,4,4,5 repeating; int 15 frac 3 saturates.
    begin
      int dexp [8] = '{4, 4, 4, 5, 4, 4, 4, 5};
      en = 1'b0;
      wr(2'd0, 6'd17, w);
      repeat (2) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      for (int p = 0; p < 8; p++) begin
        measure(1'b0, 16, m0, m1, m2, pc);
        check("dither_high_count", 32'($countones(m0)), 32'(dexp[p]));
        @(negedge clk);
      end
      en = 1'b0;
      wr(2'd0, 6'd63, w);
      repeat (2) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        measure(1'b0, 16, m0, m1, m2, pc);
        check("dither_saturate", 32'($countones(m0)), 32'd16);
        @(negedge clk);
      end
    end
`endif

    // Center-aligned duty 5: 30-cycle period, high at counts 0..4 up and 4..1 down.
    @(negedge clk);
    c_chan = 1'b0; c_data = mk(5); c_valid = 1'b1;
    #1 check("c_ready", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1 c_valid = 1'b0;
    @(negedge clk);
    c_en = 1'b1;
    wait_ps(1'b1);
    measure(1'b1, 30, m0, m1, m2, pc);
    check("center_d5_mask", m0, 32'h3C00_001F);
    check("center_ch1_idle", m1, 32'h0000_0000);
    check("center_ps_per_period", 32'(pc), 32'd1);
    @(negedge clk);
    check("center_period_30", 32'(c_ps), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
Multi-channel PWM DAC for the audio/PWM clock domain. It drives the aud_pwm path, replacing the constant-zero PWM stub at the top level. Per-channel duty values are written through a valid/ready port into shadow registers. Shadow values are applied glitch-free at period boundaries. Supports edge-aligned and center-aligned modes, parametrised in resolution and channel count.

Parameters:
CHANNELS, 2, number of independent PWM outputs (>=1)
WIDTH, 10, counter/duty resolution in bits; MAX = 2^WIDTH-1
CENTER_ALIGNED, 0, 0 = edge-aligned sawtooth counter, 1 = up/down triangle counter
FRAC_BITS, 2, fractional duty bits; used only with PWM_DITHER_EN

Ports:
clk  input  1  PWM clock (pwm_clk_g domain)
rst_n  input  1  asynchronous active-low reset
enable  input  1  run counter/outputs; low = idle
duty_valid  input  1  duty write request
duty_ready  output  1  write accepted when valid&&ready
duty_chan  input  max(1,$clog2(CHANNELS))  target channel
duty_data  input  WIDTH (WIDTH+FRAC_BITS with PWM_DITHER_EN)  new duty value
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  one-cycle pulse at start of each period

Behaviour:
- Reset (rst_n low, async): cnt=0, dir=up, active[]=0, shadow[]=0, pending[]=0, pwm_out=0, period_start=0. duty_ready reads 1 after reset.
- Edge mode: cnt runs 0..MAX, then wraps to 0. Period = 2^WIDTH cycles.
- Center mode: cnt runs 0,1..MAX,MAX-1..1, then 0. Period = 2*MAX cycles. dir flips at MAX and at 1.
- Boundary cycle = cycle in which cnt==0 while enable=1. period_start is registered and high for exactly that cycle.
- Compare: pwm_out[i] is registered, one-cycle latency. pwm_out[i](t+1) = (active[i]==MAX) ? 1 : (cnt(t) < active[i]).
  - active=0 gives constant low.
  - active=MAX gives constant high (100%).
- Handshake: duty_ready = ~pending[duty_chan] (combinational).
  - On accept: shadow[chan] <= duty_data; pending[chan] <= 1.
  - duty_chan >= CHANNELS: ready=1; the write is accepted and dropped.
- Transfer: on a boundary cycle, each channel with pending=1 copies shadow to active, and pending clears. The new duty governs the very next compare.
- Write accepted on the boundary cycle itself (pending was 0): the value is stored in shadow, pending is set, and it transfers at the following boundary.
- A second write to the same channel within a period stalls (ready=0) until the boundary clears pending. Writes to other channels are unaffected.
- enable low:
  - cnt held 0, dir=up, pwm_out=0, period_start=0.
  - Writes are still accepted, and every cycle acts as a transfer point, so pending values apply within 1 cycle.
- enable rising: the first cycle has cnt=0 and is a boundary (period_start=1).
- enable falling mid-period: outputs go low the next cycle, and the counter resets to 0.
- Reset mid-operation: all state is cleared immediately, including pending writes; no partial period is completed.

Optional Feature:
Macro PWM_DITHER_EN.
- Defined: duty_data = {int[WIDTH], frac[FRAC_BITS]}, and shadow/active hold the full width.
  - Each channel has a FRAC_BITS accumulator, reset 0. At each boundary: acc <= acc + frac.
  - On carry-out, the effective duty for that period is int+1, saturated at MAX.
  - The accumulator clears when a new value transfers in.
- Undefined: no accumulators, FRAC_BITS is ignored, and duty_data is WIDTH bits.

Test Plan:
- Reset: assert rst_n=0 mid-period with pending writes -> pwm_out=0, period_start=0, duty_ready=1; no pending value applied after release.
- WIDTH=4, edge, ch0 duty=4 -> after the next period_start, pwm_out[0] is high 4 of every 16 cycles, starting 1 cycle after cnt=0.
- ch1 writes 6 then 9 in one period -> second write has ready=0 until the boundary. Next period high=6 cycles, the following period high=9; ch0 is never stalled.
- Extremes, WIDTH=4: duty=0 -> pwm_out constant 0; duty=15 -> constant 1 across 3 periods; duty_chan=3 with CHANNELS=2 -> accepted, no output change.
- CENTER_ALIGNED=1, WIDTH=4, duty=5 -> period 30 cycles, high 9 cycles centered on cnt=0, one period_start per 30 cycles.
- PWM_DITHER_EN, WIDTH=4, FRAC_BITS=2, duty int=4 frac=1 -> high counts per period 4,4,4,5 repeating. int=15 frac=3 -> saturates at constant high.
